// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared command, address and state encodings for the memory/IO responder
package mem_io_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_cmd_e;

  localparam logic [8:0] LED_ADDR_DEFAULT = 9'h100;
  localparam logic [8:0] SW_ADDR_DEFAULT  = 9'h140;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

endpackage

// File: rtl/ram_sp.sv
// rtl/ram_sp.sv - single-port synchronous RAM with registered, read-enabled output
module ram_sp #(
  parameter int    DATA_W    = 16,
  parameter int    AW        = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] dout_q;

  // dout only moves on a read so the last loaded word stays visible
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    if (en) dout_q <= mem[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - RAM/switch/LED responder with 4-phase cmd/ready handshake and wait states
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int                ADDR_W      = 9,
  parameter int                DATA_W      = 16,
  parameter int                RAM_AW      = 8,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR    = LED_ADDR_DEFAULT,
  parameter logic [ADDR_W-1:0] SW_ADDR     = SW_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              err,
  input  logic [7:0]        SW,
  output logic [7:0]        LEDR
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  resp_state_e       state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [7:0]        led_q, led_d;
  logic [DATA_W-1:0] rd_hold_q, rd_hold_d;
  logic              rd_from_ram_q, rd_from_ram_d;

  logic [1:0]        act_cmd;
  logic [ADDR_W-1:0] act_addr;
  logic [DATA_W-1:0] act_wdata;
  logic              action;
  logic              in_ram;
  logic              ram_we;
  logic              ram_en;
  logic [DATA_W-1:0] ram_dout;

  // With zero wait states the action edge is the accept edge, so use the live inputs there
  always_comb begin
    act_cmd   = (state_q == IDLE) ? mem_cmd    : cmd_q;
    act_addr  = (state_q == IDLE) ? mem_addr   : addr_q;
    act_wdata = (state_q == IDLE) ? write_data : wdata_q;
    action    = ((state_q == IDLE) && (mem_cmd != MEM_NONE) && (WAIT_CYCLES == 0)) ||
                ((state_q == WAIT) && (cnt_q == 4'd0));
    in_ram    = (act_addr[ADDR_W-1:RAM_AW] == '0);
    ram_we    = action && (act_cmd == MEM_WRITE) && in_ram;
    ram_en    = action && (act_cmd == MEM_READ) && in_ram;
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    led_d         = led_q;
    rd_hold_d     = rd_hold_q;
    rd_from_ram_d = rd_from_ram_q;

    case (state_q)
      IDLE: begin
        if (mem_cmd != MEM_NONE) begin
          cmd_d   = mem_cmd;
          addr_d  = mem_addr;
          wdata_d = write_data;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (mem_cmd == MEM_NONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == RESP);
    err_d   = err_q && (state_d == RESP);

    if (action) begin
      case (act_cmd)
        MEM_READ: begin
          if (in_ram) begin
            rd_from_ram_d = 1'b1;
          end else if (act_addr == SW_ADDR) begin
            rd_hold_d     = {{(DATA_W-8){1'b0}}, SW};
            rd_from_ram_d = 1'b0;
          end else begin
            err_d         = 1'b1;
            rd_hold_d     = '0;
            rd_from_ram_d = 1'b0;
          end
        end
        MEM_WRITE: begin
          if (!in_ram) begin
            if (act_addr == LED_ADDR) led_d = act_wdata[7:0];
            else                      err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cmd_q         <= MEM_NONE;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
      led_q         <= '0;
      rd_hold_q     <= '0;
      rd_from_ram_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      err_q         <= err_d;
      led_q         <= led_d;
      rd_hold_q     <= rd_hold_d;
      rd_from_ram_q <= rd_from_ram_d;
    end
  end

  ram_sp #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (act_addr[RAM_AW-1:0]),
    .din  (act_wdata),
    .dout (ram_dout)
  );

  assign read_data = rd_from_ram_q ? ram_dout : rd_hold_q;
  assign mem_ready = ready_q;
  assign err       = err_q;
  assign LEDR      = led_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - bench driving three responders (0, 1 and 3 wait states) against a reference model
module tb_mem_io_responder;
  import mem_io_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  sw;

  logic [15:0] rd  [3];
  logic        rdy [3];
  logic        er  [3];
  logic [7:0]  led [3];

  int waits [3];

  logic [15:0] mem_m [256];
  bit          mem_v [256];
  logic [7:0]  led_m;
  logic [15:0] rd_m;
  bit          rd_known;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_io_responder #(
        .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 1 : 3)
      ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (rd[g]),
        .mem_ready  (rdy[g]),
        .err        (er[g]),
        .SW         (sw),
        .LEDR       (led[g])
      );
    end
  endgenerate

  task automatic run_txn(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    bit exp_err;
    int lat [3];
    exp_err = 1'b0;
    if (c == MEM_READ) begin
      if (a < 9'h100) begin
        rd_m = mem_m[a[7:0]];
        rd_known = mem_v[a[7:0]];
      end else if (a == 9'h140) begin
        rd_m = {8'h00, sw};
        rd_known = 1'b1;
      end else begin
        exp_err = 1'b1;
        rd_m = 16'h0000;
        rd_known = 1'b1;
      end
    end else if (c == MEM_WRITE) begin
      if (a < 9'h100) begin
        mem_m[a[7:0]] = d;
        mem_v[a[7:0]] = 1'b1;
      end else if (a == 9'h100) begin
        led_m = d[7:0];
      end else begin
        exp_err = 1'b1;
      end
    end else begin
      exp_err = 1'b1;
    end

    @(negedge clk);
    mem_cmd = c;
    mem_addr = a;
    write_data = d;
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        mem_addr = 9'($urandom);
        write_data = 16'($urandom);
      end
      for (int i = 0; i < 3; i++) if (lat[i] == 0 && rdy[i] === 1'b1) lat[i] = e;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end

    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (lat[i] !== waits[i] + 1) begin
        n_fail++;
        $display("FAIL latency dut%0d cmd=%0d addr=%h: got %0d edges, expected %0d", i, c, a, lat[i], waits[i] + 1);
      end
      n_cmp++;
      if (er[i] !== exp_err) begin
        n_fail++;
        $display("FAIL err dut%0d cmd=%0d addr=%h: got %b, expected %b", i, c, a, er[i], exp_err);
      end
      if (rd_known) begin
        n_cmp++;
        if (rd[i] !== rd_m) begin
          n_fail++;
          $display("FAIL read_data dut%0d cmd=%0d addr=%h: got %h, expected %h", i, c, a, rd[i], rd_m);
        end
      end
      n_cmp++;
      if (led[i] !== led_m) begin
        n_fail++;
        $display("FAIL LEDR dut%0d cmd=%0d addr=%h: got %h, expected %h", i, c, a, led[i], led_m);
      end
    end

    @(negedge clk);
    mem_cmd = MEM_NONE;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rdy[i] !== 1'b0 || er[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL release dut%0d: got ready=%b err=%b, expected 0/0", i, rdy[i], er[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_cmd = MEM_NONE;
    mem_addr = '0;
    write_data = '0;
    sw = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rdy[i] !== 1'b0 || er[i] !== 1'b0 || rd[i] !== 16'h0 || led[i] !== 8'h0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got ready=%b err=%b rd=%h led=%h, expected all zero", i, rdy[i], er[i], rd[i], led[i]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ram_rw();
    run_txn(MEM_WRITE, 9'h005, 16'hBEEF);
    run_txn(MEM_READ, 9'h005, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd[i] !== 16'hBEEF) begin
        n_fail++;
        $display("FAIL ram_readback dut%0d: got %h, expected beef", i, rd[i]);
      end
    end
    run_txn(MEM_WRITE, 9'h0FF, 16'h1234);
    run_txn(MEM_WRITE, 9'h000, 16'h5678);
    run_txn(MEM_READ, 9'h0FF, 16'h0000);
    run_txn(MEM_READ, 9'h000, 16'h0000);
  endtask

  task automatic test_io();
    sw = 8'hA5;
    run_txn(MEM_READ, 9'h140, 16'h0000);
    run_txn(MEM_WRITE, 9'h100, 16'h123C);
    run_txn(MEM_READ, 9'h005, 16'h0000);
  endtask

  task automatic test_errors();
    run_txn(MEM_READ, 9'h180, 16'h0000);
    run_txn(MEM_RSVD, 9'h005, 16'hDEAD);
    run_txn(MEM_WRITE, 9'h140, 16'h00FF);
    run_txn(MEM_READ, 9'h100, 16'h0000);
    run_txn(MEM_WRITE, 9'h1FF, 16'h4444);
    run_txn(MEM_READ, 9'h005, 16'h0000);
  endtask

  task automatic test_hold_write();
    bit held [3];
    for (int i = 0; i < 3; i++) held[i] = 1'b1;
    @(negedge clk);
    mem_cmd = MEM_WRITE;
    mem_addr = 9'h010;
    write_data = 16'h0001;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) write_data = 16'h0002;
      for (int i = 0; i < 3; i++) if (e >= waits[i] + 1 && rdy[i] !== 1'b1) held[i] = 1'b0;
    end
    mem_m[16] = 16'h0001;
    mem_v[16] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (!held[i]) begin
        n_fail++;
        $display("FAIL hold_ready dut%0d: got ready dropped while cmd held, expected steady 1", i);
      end
    end
    @(negedge clk);
    mem_cmd = MEM_NONE;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rdy[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_release dut%0d: got ready=%b, expected 0", i, rdy[i]);
      end
    end
    run_txn(MEM_READ, 9'h010, 16'h0000);
  endtask

  task automatic test_random();
    logic [1:0] c;
    logic [8:0] a;
    int r;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      sw = 8'($urandom);
      c = ($urandom_range(0, 7) == 0) ? MEM_RSVD : (($urandom_range(0, 1) == 0) ? MEM_READ : MEM_WRITE);
      r = $urandom_range(0, 9);
      if (r <= 5)      a = 9'($urandom_range(0, 31));
      else if (r == 6) a = 9'h100;
      else if (r == 7) a = 9'h140;
      else             a = 9'h180 + 9'($urandom_range(0, 127));
      run_txn(c, a, 16'($urandom));
    end
  endtask

  task automatic test_reset_midwait();
    run_txn(MEM_WRITE, 9'h100, 16'h0077);
    @(negedge clk);
    mem_cmd = MEM_WRITE;
    mem_addr = 9'h100;
    write_data = 16'h0055;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    led_m = 8'h00;
    rd_m = 16'h0000;
    rd_known = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rdy[i] !== 1'b0 || led[i] !== 8'h00 || rd[i] !== 16'h0000) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got ready=%b led=%h rd=%h, expected 0/00/0000", i, rdy[i], led[i], rd[i]);
      end
    end
    mem_cmd = MEM_NONE;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (led[i] !== 8'h00 || rdy[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL abandoned_write dut%0d: got led=%h ready=%b, expected 00/0", i, led[i], rdy[i]);
      end
    end
    run_txn(MEM_READ, 9'h005, 16'h0000);
    run_txn(MEM_READ, 9'h010, 16'h0000);
  endtask

  initial begin
    waits[0] = 0;
    waits[1] = 1;
    waits[2] = 3;
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = 16'h0000;
      mem_v[i] = 1'b0;
    end
    led_m = 8'h00;
    rd_m = 16'h0000;
    rd_known = 1'b1;

    test_reset();
    test_ram_rw();
    test_io();
    test_errors();
    test_hold_write();
    test_random();
    test_reset_midwait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
